sample_descriptor_walker: RTL and testbench
===========================================

// Module: sample_descriptor_walker
// PURPOSE
// - Walks the linked list of sample descriptors held in the sampler descriptor BRAM and
//   presents one DMA burst request per valid voice to the DMA requester (valid/ready).
// - On each accepted request, writes back the advanced address and updated status.
// - Adds loop-mode wrap, invalid-entry skipping, and a runaway-list guard.
// - Sits between the descriptor BRAM (port B) and sampler_dma_requester.
// PARAMETERS
// - BRAM_ADDR_WIDTH  6    descriptor index width; list depth = 2**BRAM_ADDR_WIDTH entries
// - BRAM_DATA_WIDTH  128  descriptor width; fixed at 4x32b, other values illegal
// - READ_LATENCY     2    BRAM read latency in clocks, 1..3
// - BURST_BYTES      256  address increment per accepted request; power of two
// PORTS
// - clk           in   1    clock
// - reset_n       in   1    asynchronous active-low reset
// - start         in   1    pulse: begin a walk at head_idx (ignored unless IDLE)
// - stop          in   1    level: abort the walk, return to IDLE, no writeback
// - head_idx      in   AW   first descriptor index, sampled on start
// - busy          out  1    high in every state except IDLE
// - walk_done     out  1    1-clk pulse when the entry with LAST set is retired
// - list_error    out  1    1-clk pulse when the runaway guard trips
// - bram_addr     out  AW   descriptor index
// - bram_rdata    in   128  descriptor read data
// - bram_wdata    out  128  writeback data
// - bram_we       out  1    write enable, 1 clk
// - req_valid     out  1    request valid
// - req_ready     in   1    request accepted when req_valid&req_ready
// - req_addr      out  32   burst start address (descriptor word0)
// - req_id        out  AW   descriptor index of request
// - req_last      out  1    LAST flag of presented entry
// - req_wrap      out  1    this burst triggers a loop wrap
// BEHAVIOUR
// - Descriptor: w0 cur_addr, w1 end_addr, w2={ctrl[7:0],len[23:0]}, w3[AW-1:0]=next idx.
// - ctrl bits: [0] VALID, [1] LAST, [2] LOOP, [7] OVF; other bits pass through unchanged.
// - Reset: FSM IDLE; all outputs 0; internal index, latched descriptor, and guard count 0.
// - FSM states: IDLE, READ, WAIT_DATA, EVAL, PRESENT, WRITEBACK, ADVANCE.
//   - IDLE -> READ on start&~stop; bram_addr<=head_idx; guard count cleared.
//   - READ: 1 clk issuing bram_addr. WAIT_DATA: hold READ_LATENCY-1 clks.
//     Descriptor is latched on the WAIT_DATA -> EVAL transition.
//   - EVAL: usable = VALID & ~OVF.
//     usable -> PRESENT; else -> ADVANCE (skipped: no request, no writeback).
//   - PRESENT: req_valid=1, all req_* held stable until req_ready; then -> WRITEBACK.
//   - WRITEBACK: bram_we=1 for 1 clk at the same index, then -> ADVANCE.
//   - ADVANCE: if LAST -> pulse walk_done -> IDLE; else bram_addr<=next idx,
//     guard count +1 -> READ.
// - Address arithmetic: nxt = cur_addr + BURST_BYTES, 32b unsigned, carry-out counts as over.
//   over = (nxt > end_addr) or carry.
//   - ~over: w0<=nxt, OVF stays 0.
//   - over & LOOP: w0<=end_addr-len (loop start), OVF stays 0, req_wrap=1.
//   - over & ~LOOP: w0 unchanged, OVF<=1; the entry is skipped on later walks.
//   - w1, w2[23:0], w3 are written back unchanged.
// - req_wrap is computed in EVAL and valid throughout PRESENT.
// - Runaway guard: when guard count reaches 2**AW with no LAST seen,
//   pulse list_error -> IDLE with no further writes.
// - stop has priority in every state:
//   - next state is IDLE; req_valid and bram_we drop the same clk;
//   - a handshake coinciding with stop is ignored (no writeback);
//   - walk_done is not pulsed.
// - Self-loop (next idx == own idx) is legal; the guard terminates it if LAST is never set.
// - start while busy is ignored. reset_n mid-walk: immediate IDLE, BRAM contents untouched.
// STRUCTURE
// - Package sampler_pkg: descriptor struct (w0..w3 fields), ctrl bit-position constants,
//   FSM state enum.
// - Sub-module: sample_desc_update (combinational: cur/end/len/ctrl -> wdata, wrap, over).
//   All other logic is in this module.
// TESTING
// - One voice (VALID|LAST), cur=0x1000, end=0x1FFF, head=0:
//   - start -> one request, req_addr=0x1000;
//   - writeback w0=0x1100;
//   - walk_done one clk after the write.
// - Chain 0->5->9, entry 9 LAST, entry 5 VALID=0:
//   - requests carry req_id 0 then 9;
//   - entry 5 is never written; bram_addr sequence is 0,5,9.
// - req_ready held low for 20 clks: req_valid and req_addr stable throughout;
//   exactly one bram_we after acceptance.
// - cur=0x1F00, end=0x1FFF:
//   - LOOP=1, len=0x1000: writeback w0=0x0FFF, req_wrap=1;
//   - LOOP=0: w0=0x1F00, OVF set, and the next walk skips the entry.
// - Next pointers form a cycle with no LAST: list_error after 64 advances (AW=6), busy drops.
// - stop asserted in the same clk as req_ready: no bram_we, FSM IDLE next clk,
//   no walk_done; a fresh start walks from head_idx.

Source files
------------

// File: rtl/sampler_pkg.sv
// Shared types for the sampler descriptor path.
//   desc_t       : one 128-bit descriptor, w0 in bits [31:0] up to w3 in [127:96]
//   CTRL_*       : bit positions inside the 8-bit ctrl field of w2
//   walk_state_t : states of the descriptor walker FSM
package sampler_pkg;

  localparam int CTRL_VALID = 0;
  localparam int CTRL_LAST  = 1;
  localparam int CTRL_LOOP  = 2;
  localparam int CTRL_OVF   = 7;

  // Packed MSB-first, so cur_addr (w0) lands in the low word of the BRAM line.
  typedef struct packed {
    logic [31:0] next_word;  // w3, low AW bits are the next index
    logic [7:0]  ctrl;       // w2[31:24]
    logic [23:0] len;        // w2[23:0], loop length in bytes
    logic [31:0] end_addr;   // w1
    logic [31:0] cur_addr;   // w0
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_DATA,
    S_EVAL,
    S_PRESENT,
    S_WRITEBACK,
    S_ADVANCE
  } walk_state_t;

endpackage

// File: rtl/sample_desc_update.sv
// Combinational next-descriptor computation for one accepted burst.
//   desc_i : descriptor as read from the BRAM
//   desc_o : descriptor to write back (only w0 and the OVF bit can change)
//   wrap_o : the burst overran end_addr and the voice loops back to end_addr - len
module sample_desc_update
  import sampler_pkg::*;
#(
  parameter int BURST_BYTES = 256
) (
  input  desc_t desc_i,
  output desc_t desc_o,
  output logic  wrap_o
);

  logic [32:0] sum;
  logic        over;

  // The 33rd bit catches a 32-bit wrap, which must count as running past the end.
  assign sum  = {1'b0, desc_i.cur_addr} + 33'(BURST_BYTES);
  assign over = sum[32] | (sum[31:0] > desc_i.end_addr);

  always_comb begin
    desc_o = desc_i;
    wrap_o = 1'b0;
    if (!over) begin
      desc_o.cur_addr = sum[31:0];
    end else if (desc_i.ctrl[CTRL_LOOP]) begin
      desc_o.cur_addr = desc_i.end_addr - {8'h00, desc_i.len};
      wrap_o          = 1'b1;
    end else begin
      // Address stays put; the voice is parked until software clears OVF.
      desc_o.ctrl[CTRL_OVF] = 1'b1;
    end
  end

endmodule

// File: rtl/sample_descriptor_walker.sv
// Walks the linked list of sample descriptors in the descriptor BRAM and issues
// one DMA burst request per usable voice, writing back the advanced descriptor.
//   clk, reset_n            : clock, asynchronous active-low reset
//   start, stop, head_idx   : walk control (start pulse, stop level, list head)
//   busy, walk_done,
//   list_error              : status (busy level, end-of-list and runaway pulses)
//   bram_addr/rdata/wdata/we: descriptor BRAM port B
//   req_valid/ready/addr/
//   id/last/wrap            : burst request toward the DMA requester
// Read latency is counted from the clock edge that launches bram_addr.
module sample_descriptor_walker
  import sampler_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int BRAM_DATA_WIDTH = 128,
  parameter int READ_LATENCY    = 2,
  parameter int BURST_BYTES     = 256
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [BRAM_ADDR_WIDTH-1:0] head_idx,
  output logic                       busy,
  output logic                       walk_done,
  output logic                       list_error,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_rdata,
  output logic [BRAM_DATA_WIDTH-1:0] bram_wdata,
  output logic                       bram_we,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [31:0]                req_addr,
  output logic [BRAM_ADDR_WIDTH-1:0] req_id,
  output logic                       req_last,
  output logic                       req_wrap
);

  localparam int         AW        = BRAM_ADDR_WIDTH;
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 2);

  walk_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] guard_q, guard_d;
  logic [1:0]    wait_q, wait_d;
  desc_t         desc_q, desc_d;
  desc_t         wb_q, wb_d;
  logic          wrap_q, wrap_d;

  desc_t         upd_desc;
  logic          upd_wrap;
  logic          usable;
  logic          is_last;

  sample_desc_update #(
    .BURST_BYTES (BURST_BYTES)
  ) u_update (
    .desc_i (desc_q),
    .desc_o (upd_desc),
    .wrap_o (upd_wrap)
  );

  assign usable  = desc_q.ctrl[CTRL_VALID] & ~desc_q.ctrl[CTRL_OVF];
  assign is_last = desc_q.ctrl[CTRL_LAST];

  assign busy       = (state_q != S_IDLE);
  assign bram_addr  = idx_q;
  assign bram_wdata = wb_q;
  assign req_addr   = desc_q.cur_addr;
  assign req_id     = idx_q;
  assign req_last   = is_last;
  assign req_wrap   = wrap_q;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    guard_d    = guard_q;
    wait_d     = wait_q;
    desc_d     = desc_q;
    wb_d       = wb_q;
    wrap_d     = wrap_q;
    req_valid  = 1'b0;
    bram_we    = 1'b0;
    walk_done  = 1'b0;
    list_error = 1'b0;

    // stop wins over everything: request and write strobes vanish this cycle.
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            idx_d   = head_idx;
            guard_d = '0;
            state_d = S_READ;
          end
        end
        S_READ: begin
          if (READ_LATENCY <= 1) begin
            desc_d  = bram_rdata;
            state_d = S_EVAL;
          end else begin
            wait_d  = WAIT_INIT;
            state_d = S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (wait_q == 2'd0) begin
            desc_d  = bram_rdata;
            state_d = S_EVAL;
          end else begin
            wait_d = wait_q - 2'd1;
          end
        end
        S_EVAL: begin
          wb_d    = upd_desc;
          wrap_d  = usable & upd_wrap;
          state_d = usable ? S_PRESENT : S_ADVANCE;
        end
        S_PRESENT: begin
          req_valid = 1'b1;
          if (req_ready) state_d = S_WRITEBACK;
        end
        S_WRITEBACK: begin
          bram_we = 1'b1;
          state_d = S_ADVANCE;
        end
        S_ADVANCE: begin
          if (is_last) begin
            walk_done = 1'b1;
            state_d   = S_IDLE;
          end else if (&guard_q) begin
            // This would be advance number 2**AW without a LAST entry.
            list_error = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d   = desc_q.next_word[AW-1:0];
            guard_d = guard_q + 1'b1;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the descriptor copies are plain registers, not a
  // memory, so clearing them on reset is cheap and keeps outputs at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      guard_q <= '0;
      wait_q  <= '0;
      desc_q  <= '0;
      wb_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      guard_q <= guard_d;
      wait_q  <= wait_d;
      desc_q  <= desc_d;
      wb_q    <= wb_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_sample_descriptor_walker.sv
module tb_sample_descriptor_walker;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, stop;
  logic [AW-1:0] head_idx;
  logic          busy, walk_done, list_error;
  logic [AW-1:0] bram_addr;
  logic [127:0]  bram_rdata, bram_wdata;
  logic          bram_we;
  logic          req_valid, req_ready;
  logic [31:0]   req_addr;
  logic [AW-1:0] req_id;
  logic          req_last, req_wrap;

  always #5 clk = ~clk;

  sample_descriptor_walker dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .head_idx   (head_idx),
    .busy       (busy),
    .walk_done  (walk_done),
    .list_error (list_error),
    .bram_addr  (bram_addr),
    .bram_rdata (bram_rdata),
    .bram_wdata (bram_wdata),
    .bram_we    (bram_we),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_id     (req_id),
    .req_last   (req_last),
    .req_wrap   (req_wrap)
  );

  // Descriptor BRAM model: one register stage, loaded by the bench via ld_*.
  logic [127:0]  mem [64];
  logic [127:0]  rd_q;
  logic          ld_en;
  logic [AW-1:0] ld_idx;
  logic [127:0]  ld_data;

  always @(posedge clk) begin
    rd_q <= mem[bram_addr];
    if (ld_en) mem[ld_idx] <= ld_data;
    else if (bram_we) mem[bram_addr] <= bram_wdata;
  end
  assign bram_rdata = rd_q;

  // Scoreboard and observation state.
  logic [39:0]  exp_req [$];   // {addr, id, last, wrap}
  logic [133:0] exp_wr  [$];   // {idx, data}
  logic [AW-1:0] addr_log [$];
  int n_cmp = 0, n_mis = 0;
  int cyc = 0, we_cnt = 0, done_cnt = 0, err_cnt = 0, req_cnt = 0;
  int we_cyc = 0, done_cyc = 0;
  logic prev_busy = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] cur, input logic [31:0] endv,
                                      input logic [7:0] ctrl, input logic [23:0] len,
                                      input int nxt);
    return {32'(nxt), ctrl, len, endv, cur};
  endfunction

  // Reference update: 64-bit arithmetic so a 32-bit carry shows up as "past end".
  function automatic logic [127:0] model_wb(input logic [127:0] d, output logic wrap);
    logic [63:0] nxt;
    logic [127:0] r;
    r    = d;
    wrap = 1'b0;
    nxt  = {32'h0, d[31:0]} + 64'd256;
    if (nxt <= {32'h0, d[63:32]}) r[31:0] = nxt[31:0];
    else if (d[90]) begin
      r[31:0] = d[63:32] - {8'h00, d[87:64]};
      wrap    = 1'b1;
    end else r[95] = 1'b1;
    return r;
  endfunction

  task automatic push_voice(input logic [AW-1:0] idx, input logic [127:0] d);
    logic [127:0] wb;
    logic wrap;
    wb = model_wb(d, wrap);
    exp_req.push_back({d[31:0], idx, d[89], wrap});
    exp_wr.push_back({idx, wb});
  endtask

  task automatic load(input logic [AW-1:0] idx, input logic [127:0] d);
    @(posedge clk); #1;
    ld_idx = idx; ld_data = d; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Watches the DUT on falling edges and compares each transaction as it appears.
  task automatic monitor();
    logic [39:0]  er;
    logic [133:0] ew;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (req_valid && req_ready) begin
          req_cnt++;
          check("req_pending", 160'(exp_req.size() > 0), 160'(1));
          if (exp_req.size() > 0) begin
            er = exp_req.pop_front();
            check("req", {req_addr, req_id, req_last, req_wrap}, er);
          end
        end
        if (bram_we) begin
          we_cnt++;
          we_cyc = cyc;
          check("wr_pending", 160'(exp_wr.size() > 0), 160'(1));
          if (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            check("wr", {bram_addr, bram_wdata}, ew);
          end
        end
        if (walk_done) begin done_cnt++; done_cyc = cyc; end
        if (list_error) err_cnt++;
        if (busy && (!prev_busy || bram_addr != prev_addr)) addr_log.push_back(bram_addr);
        prev_busy = busy;
        prev_addr = bram_addr;
      end
    end
  endtask

  task automatic do_walk(input logic [AW-1:0] head, input int budget);
    int n;
    @(posedge clk); #1;
    head_idx = head; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("walk_timeout", 160'(busy), 160'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_req_valid(input int budget);
    int n;
    n = 0;
    while (!req_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_valid_seen", 160'(req_valid), 160'(1));
  endtask

  initial begin
    logic [127:0] d;
    int s_we, s_done, s_err, s_log, bad;

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; head_idx = '0; req_ready = 1'b1;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    fork monitor(); join_none

    for (int i = 0; i < 64; i++) load(AW'(i), 128'h0);
    check("reset_state", {busy, req_valid, bram_we, walk_done, list_error, req_wrap, req_last,
                          bram_addr, req_id, req_addr, bram_wdata}, 160'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // One voice, VALID|LAST.
    d = mk(32'h1000, 32'h1FFF, 8'h03, 24'h100, 0);
    load(0, d);
    push_voice(0, d);
    s_done = done_cnt;
    do_walk(0, 200);
    check("one_voice_done", 160'(done_cnt - s_done), 160'(1));
    check("one_voice_w0", mem[0][31:0], 32'h1100);
    check("done_after_we", 160'(done_cyc - we_cyc), 160'(1));

    // Chain 0 -> 5 -> 9, entry 5 invalid.
    load(0, mk(32'h2000, 32'h2FFF, 8'h01, 24'h0, 5));
    load(5, mk(32'h5000, 32'h5FFF, 8'h00, 24'h0, 9));
    load(9, mk(32'h9000, 32'h9FFF, 8'h03, 24'h0, 0));
    push_voice(0, mem[0]);
    push_voice(9, mem[9]);
    s_log = addr_log.size();
    do_walk(0, 300);
    check("chain_addr_count", 160'(addr_log.size() - s_log), 160'(3));
    if (addr_log.size() - s_log == 3)
      check("chain_addr_seq", {addr_log[s_log], addr_log[s_log+1], addr_log[s_log+2]},
            {6'd0, 6'd5, 6'd9});
    check("chain_skip_untouched", mem[5], mk(32'h5000, 32'h5FFF, 8'h00, 24'h0, 9));

    // Backpressure: ready low for 20 clocks.
    d = mk(32'h1000, 32'h1FFF, 8'h03, 24'h100, 0);
    load(0, d);
    push_voice(0, d);
    req_ready = 1'b0;
    s_we = we_cnt;
    @(posedge clk); #1; head_idx = 0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_req_valid(20);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!req_valid || req_addr != 32'h1000 || bram_we) bad++;
    end
    check("hold_stable", 160'(bad), 160'(0));
    req_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("hold_one_we", 160'(we_cnt - s_we), 160'(1));
    check("hold_idle", 160'(busy), 160'(0));

    // Loop wrap.
    d = mk(32'h1F00, 32'h1FFF, 8'h07, 24'h1000, 0);
    load(0, d);
    push_voice(0, d);
    do_walk(0, 200);
    check("loop_w0", mem[0][31:0], 32'h0FFF);

    // Overrun without loop: OVF set, then skipped on the next walk.
    d = mk(32'h1F00, 32'h1FFF, 8'h03, 24'h1000, 0);
    load(0, d);
    push_voice(0, d);
    do_walk(0, 200);
    check("ovf_w0", mem[0][31:0], 32'h1F00);
    check("ovf_bit", 160'(mem[0][95]), 160'(1));
    s_we = we_cnt; s_done = done_cnt;
    s_err = req_cnt;
    do_walk(0, 200);
    check("ovf_skip_no_req", 160'(req_cnt - s_err), 160'(0));
    check("ovf_skip_no_we", 160'(we_cnt - s_we), 160'(0));
    check("ovf_skip_done", 160'(done_cnt - s_done), 160'(1));

    // Runaway list: 0 <-> 1 with no LAST.
    load(0, mk(32'h0, 32'h0, 8'h00, 24'h0, 1));
    load(1, mk(32'h0, 32'h0, 8'h00, 24'h0, 0));
    s_log = addr_log.size(); s_err = err_cnt; s_done = done_cnt; s_we = we_cnt;
    do_walk(0, 2000);
    check("guard_advances", 160'(addr_log.size() - s_log - 1), 160'(63));
    check("guard_error", 160'(err_cnt - s_err), 160'(1));
    check("guard_no_done", 160'(done_cnt - s_done), 160'(0));
    check("guard_no_we", 160'(we_cnt - s_we), 160'(0));
    check("guard_busy", 160'(busy), 160'(0));

    // stop together with req_ready, then a fresh walk from head 3.
    d = mk(32'h4000, 32'h4FFF, 8'h03, 24'h0, 0);
    load(3, d);
    req_ready = 1'b0;
    s_we = we_cnt; s_done = done_cnt;
    @(posedge clk); #1; head_idx = 3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_req_valid(20);
    stop = 1'b1; req_ready = 1'b1;
    @(posedge clk); #1;
    check("stop_idle", 160'(busy), 160'(0));
    stop = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stop_no_we", 160'(we_cnt - s_we), 160'(0));
    check("stop_no_done", 160'(done_cnt - s_done), 160'(0));
    check("stop_mem", mem[3], d);
    push_voice(3, d);
    s_log = addr_log.size();
    do_walk(3, 200);
    check("restart_head", 160'(addr_log.size() > s_log ? addr_log[s_log] : 6'h3F), 160'(3));
    check("restart_w0", mem[3][31:0], 32'h4100);
    check("restart_done", 160'(done_cnt - s_done), 160'(1));

    check("req_queue_empty", 160'(exp_req.size()), 160'(0));
    check("wr_queue_empty", 160'(exp_wr.size()), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
